// File: rtl/sdram_wb_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_wb_arbiter
//   Two-master Wishbone arbiter in front of the single Wishbone slave port of
//   the SDRAM controller. M0 is the video/sound DMA (read bursts only), M1 is
//   the CPU (single or burst, read or write). One clock domain (wb_clk).
//
//   A grant is decided in IDLE and registered, so a request reaches the slave
//   one cycle after it is raised. The grant is held until the owning master
//   drops cyc. A one-cycle GAP with s_cyc/s_stb low then follows, so the slave
//   always sees a rising request edge for the next transfer.
//
//   Optional feature macro: SDRAM_ARB_STARVE_GUARD_EN
//     defined   : M1 wait counter; once it reaches STARVE_LIMIT, the next IDLE
//                 decision grants M1 ahead of M0. A running M0 burst is never
//                 cut short.
//     undefined : strict fixed priority M0 > M1 (M1 may starve).
//
// Ports
//   wb_clk, wb_rst_n              clock, asynchronous active-low reset
//   m0_adr/m0_cti/m0_stb/m0_cyc   DMA request (reads only)
//   m0_ack, m0_dat_o              DMA ack / read data
//   m1_adr/m1_dat_i/m1_sel/m1_cti/m1_stb/m1_cyc/m1_we   CPU request
//   m1_ack, m1_dat_o              CPU ack / read data
//   s_adr/s_dat_o/s_sel/s_cti/s_stb/s_cyc/s_we          to SDRAM slave
//   s_dat_i, s_ack                from SDRAM slave
//   gnt                           one-hot grant {M1,M0}, 00 = none
// -----------------------------------------------------------------------------
module sdram_wb_arbiter #(
  parameter int AW           = 24,
  parameter int STARVE_LIMIT = 64
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  // M0: DMA
  input  logic [AW-1:0] m0_adr,
  input  logic [2:0]    m0_cti,
  input  logic          m0_stb,
  input  logic          m0_cyc,
  output logic          m0_ack,
  output logic [31:0]   m0_dat_o,
  // M1: CPU
  input  logic [AW-1:0] m1_adr,
  input  logic [31:0]   m1_dat_i,
  input  logic [3:0]    m1_sel,
  input  logic [2:0]    m1_cti,
  input  logic          m1_stb,
  input  logic          m1_cyc,
  input  logic          m1_we,
  output logic          m1_ack,
  output logic [31:0]   m1_dat_o,
  // SDRAM slave
  output logic [AW-1:0] s_adr,
  output logic [31:0]   s_dat_o,
  output logic [3:0]    s_sel,
  output logic [2:0]    s_cti,
  output logic          s_stb,
  output logic          s_cyc,
  output logic          s_we,
  input  logic [31:0]   s_dat_i,
  input  logic          s_ack,
  // status
  output logic [1:0]    gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic m0_req;
  logic m1_req;
  logic starved;

  assign m0_req = m0_cyc & m0_stb;
  assign m1_req = m1_cyc & m1_stb;

`ifdef SDRAM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;

  assign starved = (starve_cnt >= CW'(STARVE_LIMIT));

  // M1 wait counter: counts cycles M1 requests while not owning the bus,
  // saturates at the limit, clears when M1 is granted.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      starve_cnt <= {CW{1'b0}};
    end else if ((state != GNT1) && (state_nxt == GNT1)) begin
      starve_cnt <= {CW{1'b0}};
    end else if (m1_req && (state != GNT1) && !starved) begin
      starve_cnt <= starve_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt <= starve_cnt;
    end
  end
`else
  logic unused_starve_limit;

  assign starved             = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT == 0);
`endif

  // State register.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: arbitration in IDLE, hold while owner keeps cyc, then GAP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (starved && m1_req) begin
          state_nxt = GNT1;
        end else if (m0_req) begin
          state_nxt = GNT0;
        end else if (m1_req) begin
          state_nxt = GNT1;
        end else begin
          state_nxt = IDLE;
        end
      end
      GNT0: begin
        if (!m0_cyc) begin
          state_nxt = GAP;
        end else begin
          state_nxt = GNT0;
        end
      end
      GNT1: begin
        if (!m1_cyc) begin
          state_nxt = GAP;
        end else begin
          state_nxt = GNT1;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Downstream mux and ack routing, driven from the registered state only.
  // M0 never writes, so its write path is tied off.
  always_comb begin
    s_adr   = {AW{1'b0}};
    s_dat_o = 32'h0000_0000;
    s_sel   = 4'b0000;
    s_cti   = 3'b000;
    s_stb   = 1'b0;
    s_cyc   = 1'b0;
    s_we    = 1'b0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    gnt     = 2'b00;
    case (state)
      GNT0: begin
        s_adr   = m0_adr;
        s_dat_o = 32'h0000_0000;
        s_sel   = 4'b1111;
        s_cti   = m0_cti;
        s_stb   = m0_stb;
        s_cyc   = m0_cyc;
        s_we    = 1'b0;
        m0_ack  = s_ack;
        gnt     = 2'b01;
      end
      GNT1: begin
        s_adr   = m1_adr;
        s_dat_o = m1_dat_i;
        s_sel   = m1_sel;
        s_cti   = m1_cti;
        s_stb   = m1_stb;
        s_cyc   = m1_cyc;
        s_we    = m1_we;
        m1_ack  = s_ack;
        gnt     = 2'b10;
      end
      default: begin
        s_adr   = {AW{1'b0}};
        s_cyc   = 1'b0;
      end
    endcase
  end

  // Read data is fanned out to both masters; only the acked one consumes it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_wb_arbiter
//   Directed scenarios (reset, single read, DMA burst, tie, CPU write, async
//   reset, starvation behaviour) followed by a randomized phase in which two
//   random masters and a random slave are checked every cycle against a
//   bus-ownership reference model. Honours SDRAM_ARB_STARVE_GUARD_EN.
// -----------------------------------------------------------------------------
module tb_sdram_wb_arbiter;

  localparam int AW    = 24;
  localparam int LIMIT = 8;

  logic          wb_clk = 1'b0;
  logic          wb_rst_n;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [2:0]    m0_cti, m1_cti, s_cti;
  logic          m0_stb, m0_cyc, m0_ack;
  logic          m1_stb, m1_cyc, m1_we, m1_ack;
  logic [31:0]   m0_dat_o, m1_dat_o, m1_dat_i, s_dat_o, s_dat_i;
  logic [3:0]    m1_sel, s_sel;
  logic          s_stb, s_cyc, s_we, s_ack;
  logic [1:0]    gnt;

  int checks   = 0;
  int failures = 0;

  // reference model: who owns the bus (-1 none, 0 DMA, 1 CPU), gap flag,
  // and how long the CPU has been kept waiting
  int own      = -1;
  bit in_gap   = 1'b0;
  int wait_cnt = 0;

  sdram_wb_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m0_adr(m0_adr), .m0_cti(m0_cti), .m0_stb(m0_stb), .m0_cyc(m0_cyc),
    .m0_ack(m0_ack), .m0_dat_o(m0_dat_o),
    .m1_adr(m1_adr), .m1_dat_i(m1_dat_i), .m1_sel(m1_sel), .m1_cti(m1_cti),
    .m1_stb(m1_stb), .m1_cyc(m1_cyc), .m1_we(m1_we),
    .m1_ack(m1_ack), .m1_dat_o(m1_dat_o),
    .s_adr(s_adr), .s_dat_o(s_dat_o), .s_sel(s_sel), .s_cti(s_cti),
    .s_stb(s_stb), .s_cyc(s_cyc), .s_we(s_we),
    .s_dat_i(s_dat_i), .s_ack(s_ack),
    .gnt(gnt)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_adr = '0; m0_cti = 3'b000; m0_stb = 1'b0; m0_cyc = 1'b0;
    m1_adr = '0; m1_dat_i = 32'h0; m1_sel = 4'h0; m1_cti = 3'b000;
    m1_stb = 1'b0; m1_cyc = 1'b0; m1_we = 1'b0;
    s_dat_i = 32'h0; s_ack = 1'b0;
  endtask

  // Advance the ownership model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit r0, r1, starved;
    int prev;
    r0      = m0_cyc && m0_stb;
    r1      = m1_cyc && m1_stb;
    starved = 1'b0;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
    starved = (wait_cnt >= LIMIT);
`endif
    prev = own;
    if (in_gap) begin
      own = -1; in_gap = 1'b0;
    end else if (own == -1) begin
      if (r1 && starved)  own = 1;
      else if (r0)        own = 0;
      else if (r1)        own = 1;
    end else if ((own == 0 && !m0_cyc) || (own == 1 && !m1_cyc)) begin
      own = -1; in_gap = 1'b1;
    end
    if (prev != 1 && own == 1)                        wait_cnt = 0;
    else if (r1 && prev != 1 && wait_cnt < LIMIT)     wait_cnt++;
  endtask

  initial begin : main
    int acks, waited, granted_m1, m0_run, hold0, hold1, idle0, idle1;
    logic [1:0]    exp_gnt;
    logic          exp_cyc, exp_stb;
    logic [AW-1:0] exp_adr;

    idle_inputs();
    wb_rst_n = 1'b0;
    #12;
    // reset state
    check("rst_gnt", gnt, 2'b00);
    check("rst_s_cyc", s_cyc, 1'b0);
    check("rst_acks", {m0_ack, m1_ack}, 2'b00);
    check("rst_s_adr", s_adr, 24'h0);
    tick();
    wb_rst_n = 1'b1;
    tick(); tick();
    check("idle_gnt", gnt, 2'b00);

    // M1 single read
    m1_adr = 24'h000104; m1_cyc = 1'b1; m1_stb = 1'b1;
    #2 check("m1_latency_gnt", gnt, 2'b00);
    tick();
    check("m1_gnt", gnt, 2'b10);
    check("m1_s_adr", s_adr, 24'h000104);
    check("m1_s_cyc", {s_cyc, s_stb}, 2'b11);
    s_ack = 1'b1; s_dat_i = 32'hDEADBEEF;
    #2;
    check("m1_ack", m1_ack, 1'b1);
    check("m1_dat", m1_dat_o, 32'hDEADBEEF);
    check("m1_m0_ack", m0_ack, 1'b0);
    tick();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    s_ack = 1'b1;  // late ack during gap must be dropped
    #2;
    check("gap_gnt", gnt, 2'b00);
    check("gap_s_cyc", s_cyc, 1'b0);
    check("gap_late_ack", {m0_ack, m1_ack}, 2'b00);
    tick();
    s_ack = 1'b0;
    check("after_gap_gnt", gnt, 2'b00);

    // M0 burst, with M1 write data parked on its inputs
    m1_dat_i = 32'hA5A5A5A5; m1_sel = 4'h3; m1_we = 1'b1;
    m0_adr = 24'h010000; m0_cti = 3'b010; m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    acks = 0;
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b1; s_dat_i = 32'h1000 + b;
      #2;
      check("burst_gnt", gnt, 2'b01);
      check("burst_no_write", {s_we, s_sel, s_dat_o}, {1'b0, 4'hF, 32'h0});
      check("burst_dat", m0_dat_o, 32'h1000 + b);
      acks += int'(m0_ack);
      tick();
    end
    s_ack = 1'b0;
    #2 check("burst_hold_gnt", gnt, 2'b01);
    check("burst_ack_count", acks, 4);
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'h0; m1_dat_i = 32'h0;
    tick(); tick();

    // simultaneous requests
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_cti = 3'b000;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 24'h000200; m1_cti = 3'b000;
    tick();
    s_ack = 1'b1;
    #2;
    check("tie_gnt", gnt, 2'b01);
    check("tie_acks", {m1_ack, m0_ack}, 2'b01);
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    check("tie_gap", {gnt, s_cyc}, 3'b000);
    tick();
    tick();
    check("tie_m1_gnt", gnt, 2'b10);
    check("tie_m1_adr", s_adr, 24'h000200);
    s_ack = 1'b1;
    #2 check("tie_m1_ack", {m1_ack, m0_ack}, 2'b10);
    tick();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick(); tick();

    // M1 write, then async reset in the middle of it
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'b0011;
    m1_dat_i = 32'h12345678; m1_adr = 24'h000300;
    tick();
    check("wr_gnt", gnt, 2'b10);
    check("wr_path", {s_we, s_sel, s_dat_o}, {1'b1, 4'b0011, 32'h12345678});
    s_ack = 1'b1;
    #1 wb_rst_n = 1'b0;
    #1;
    check("async_rst_gnt", gnt, 2'b00);
    check("async_rst_bus", {s_cyc, s_stb, s_we, m1_ack}, 4'b0000);
    check("async_rst_s_dat_o", s_dat_o, 32'h0);
    tick();
    idle_inputs();
    wb_rst_n = 1'b1;
    tick();

    // M0 back-to-back bursts with M1 pending
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_cti = 3'b010;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0;
    waited = 0; granted_m1 = 0; m0_run = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (gnt == 2'b10) begin
        granted_m1 = 1;
        break;
      end
      waited++;
      if (gnt == 2'b01) m0_run++;
      if (m0_run == 4) begin
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_run = 0;
      end else begin
        m0_cyc = 1'b1; m0_stb = 1'b1;
      end
    end
`ifdef SDRAM_ARB_STARVE_GUARD_EN
    check("guard_m1_granted", granted_m1, 1);
    check("guard_waited_enough", waited >= LIMIT, 1'b1);
`else
    check("noguard_m1_starved", granted_m1, 0);
`endif
    tick();
    idle_inputs();
    wb_rst_n = 1'b0;
    tick();
    wb_rst_n = 1'b1;
    own = -1; in_gap = 1'b0; wait_cnt = 0;

    // randomized traffic against the ownership model
    hold0 = 0; hold1 = 0; idle0 = 0; idle1 = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge wb_clk);
      model_step();
      #1;
      if (m0_cyc) begin
        if (own == 0) begin
          if (hold0 == 0) begin
            m0_cyc = 1'b0; m0_stb = 1'b0; idle0 = $urandom_range(0, 3);
          end else hold0--;
        end
      end else if (idle0 > 0) idle0--;
      else if ($urandom_range(0, 1) == 1) begin
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = AW'($urandom);
        m0_cti = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b000;
        hold0 = $urandom_range(0, 5);
      end
      if (m1_cyc) begin
        if (own == 1) begin
          if (hold1 == 0) begin
            m1_cyc = 1'b0; m1_stb = 1'b0; idle1 = $urandom_range(0, 3);
          end else hold1--;
        end
      end else if (idle1 > 0) idle1--;
      else if ($urandom_range(0, 1) == 1) begin
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = AW'($urandom);
        m1_we = 1'($urandom); m1_dat_i = $urandom; m1_sel = 4'($urandom);
        hold1 = $urandom_range(0, 5);
      end
      s_ack = 1'($urandom); s_dat_i = $urandom;
      #3;
      exp_gnt = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
      exp_cyc = (own == 0) ? m0_cyc : (own == 1) ? m1_cyc : 1'b0;
      exp_stb = (own == 0) ? m0_stb : (own == 1) ? m1_stb : 1'b0;
      exp_adr = (own == 0) ? m0_adr : (own == 1) ? m1_adr : '0;
      check("rnd_gnt", gnt, exp_gnt);
      check("rnd_s_cyc_stb", {s_cyc, s_stb}, {exp_cyc, exp_stb});
      check("rnd_s_adr", s_adr, exp_adr);
      check("rnd_acks", {m1_ack, m0_ack}, {(own == 1) && s_ack, (own == 0) && s_ack});
      check("rnd_dat", {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
      if (own == 1) check("rnd_wr_path", {s_we, s_sel, s_dat_o}, {m1_we, m1_sel, m1_dat_i});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
